// File: rtl/stk_pipe_sched.sv
// rtl/stk_pipe_sched.sv - round-robin admission scheduler with per-engine and credit-based in-flight limits
module stk_pipe_sched #(
    parameter int ENGS_N    = 4,
    parameter int CREDITS_N = 4,
    parameter int ENGID_W   = $clog2(ENGS_N),
    parameter int CRED_W    = $clog2(CREDITS_N + 1)
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic [ENGS_N-1:0]   i_req,
    input  logic [ENGS_N-1:0]   i_req_alloc,
    output logic [ENGS_N-1:0]   o_gnt,
    output logic                o_issue_vld,
    output logic [ENGID_W-1:0]  o_issue_engid,
    input  logic                i_al_empty_r,
    input  logic                i_al_busy_r,
    output logic                o_al_alloc,
    input  logic                i_wrbk_vld,
    input  logic [ENGID_W-1:0]  i_wrbk_engid,
    output logic [ENGS_N-1:0]   o_inflight_r,
    output logic [CRED_W-1:0]   o_credits_r,
    output logic                o_err_r
);

    localparam logic [CRED_W-1:0]  CRED_MAX = CRED_W'(CREDITS_N);
    localparam logic [ENGID_W:0]   ENG_LIM  = (ENGID_W + 1)'(ENGS_N);

    logic                r_rdy;
    logic [ENGID_W-1:0]  r_rr_ptr;
    logic [ENGS_N-1:0]   r_inflight;
    logic [CRED_W-1:0]   r_credits;
    logic                r_err;

    logic [ENGS_N-1:0]   w_elig;
    logic [ENGS_N-1:0]   w_gnt;
    logic [ENGID_W-1:0]  w_engid;
    logic                w_issue;
    logic                w_eng_ok;
    logic                w_ret_ok;
    logic                w_ret_bad;
    logic [ENGID_W-1:0]  w_next_ptr;

    // Per-engine eligibility: ready, requesting, idle, a credit available, allocator usable if needed
    always_comb begin
        w_elig = '0;
        for (int e = 0; e < ENGS_N; e++) begin
            w_elig[e] = r_rdy & i_req[e] & ~r_inflight[e] & (r_credits != '0)
                        & ~(i_req_alloc[e] & (i_al_empty_r | i_al_busy_r));
        end
    end

    // Round-robin pick: first eligible engine starting at the pointer, wrapping modulo ENGS_N
    always_comb begin
        int idx;
        w_gnt   = '0;
        w_engid = '0;
        w_issue = 1'b0;
        idx     = 0;
        for (int i = 0; i < ENGS_N; i++) begin
            idx = int'(r_rr_ptr) + i;
            if (idx >= ENGS_N) begin
                idx = idx - ENGS_N;
            end
            if (!w_issue && w_elig[idx]) begin
                w_issue     = 1'b1;
                w_gnt[idx]  = 1'b1;
                w_engid     = idx[ENGID_W-1:0];
            end
        end
    end

    // Retire qualification: only a retire that matches an outstanding op may touch state
    always_comb begin
        w_eng_ok   = ({1'b0, i_wrbk_engid} < ENG_LIM);
        w_ret_ok   = i_wrbk_vld & w_eng_ok & r_inflight[i_wrbk_engid] & (r_credits != CRED_MAX);
        w_ret_bad  = i_wrbk_vld & ~w_ret_ok;
        w_next_ptr = (int'(w_engid) == ENGS_N - 1) ? '0 : w_engid + ENGID_W'(1);
    end

    // Scheduler state: ready flag, RR pointer, in-flight mask, credit count, sticky error
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_rdy      <= 1'b0;
            r_rr_ptr   <= '0;
            r_inflight <= '0;
            r_credits  <= CRED_MAX;
            r_err      <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
            if (w_issue) begin
                r_rr_ptr <= w_next_ptr;
            end
            for (int e = 0; e < ENGS_N; e++) begin
                if (w_issue && int'(w_engid) == e) begin
                    r_inflight[e] <= 1'b1;
                end else if (w_ret_ok && int'(i_wrbk_engid) == e) begin
                    r_inflight[e] <= 1'b0;
                end
            end
            if (w_issue && !w_ret_ok) begin
                r_credits <= r_credits - CRED_W'(1);
            end else if (!w_issue && w_ret_ok) begin
                r_credits <= r_credits + CRED_W'(1);
            end
            if (w_ret_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_gnt         = w_gnt;
    assign o_issue_vld   = w_issue;
    assign o_issue_engid = w_engid;
    assign o_al_alloc    = w_issue & i_req_alloc[w_engid];
    assign o_inflight_r  = r_inflight;
    assign o_credits_r   = r_credits;
    assign o_err_r       = r_err;

endmodule

// File: tb/tb_stk_pipe_sched.sv
// tb/tb_stk_pipe_sched.sv - directed self-checking bench for stk_pipe_sched
module tb_stk_pipe_sched;

    logic        clk;
    logic        arst_n;
    logic [3:0]  i_req;
    logic [3:0]  i_req_alloc;
    logic [3:0]  o_gnt;
    logic        o_issue_vld;
    logic [1:0]  o_issue_engid;
    logic        i_al_empty_r;
    logic        i_al_busy_r;
    logic        o_al_alloc;
    logic        i_wrbk_vld;
    logic [1:0]  i_wrbk_engid;
    logic [3:0]  o_inflight_r;
    logic [2:0]  o_credits_r;
    logic        o_err_r;

    int n_chk;
    int n_bad;

    stk_pipe_sched #(.ENGS_N(4), .CREDITS_N(4)) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .i_req         (i_req),
        .i_req_alloc   (i_req_alloc),
        .o_gnt         (o_gnt),
        .o_issue_vld   (o_issue_vld),
        .o_issue_engid (o_issue_engid),
        .i_al_empty_r  (i_al_empty_r),
        .i_al_busy_r   (i_al_busy_r),
        .o_al_alloc    (o_al_alloc),
        .i_wrbk_vld    (i_wrbk_vld),
        .i_wrbk_engid  (i_wrbk_engid),
        .o_inflight_r  (o_inflight_r),
        .o_credits_r   (o_credits_r),
        .o_err_r       (o_err_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // advance one clock, then apply this cycle's inputs; checks follow mid-cycle
    task automatic cyc(input logic [3:0] req, input logic [3:0] alc, input logic emp,
                       input logic bsy, input logic wv, input logic [1:0] weng);
        @(posedge clk);
        #1;
        i_req        = req;
        i_req_alloc  = alc;
        i_al_empty_r = emp;
        i_al_busy_r  = bsy;
        i_wrbk_vld   = wv;
        i_wrbk_engid = weng;
        #2;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        arst_n       = 1'b0;
        i_req        = 4'b1111;
        i_req_alloc  = 4'b0000;
        i_al_empty_r = 1'b0;
        i_al_busy_r  = 1'b0;
        i_wrbk_vld   = 1'b0;
        i_wrbk_engid = 2'd0;
        repeat (3) @(posedge clk);
        #3;
        // T1: reset values
        chk("rst_gnt", 32'(o_gnt), 32'h0);
        chk("rst_vld", 32'(o_issue_vld), 32'h0);
        chk("rst_engid", 32'(o_issue_engid), 32'h0);
        chk("rst_alloc", 32'(o_al_alloc), 32'h0);
        chk("rst_infl", 32'(o_inflight_r), 32'h0);
        chk("rst_cred", 32'(o_credits_r), 32'd4);
        chk("rst_err", 32'(o_err_r), 32'h0);

        cyc(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        arst_n = 1'b1;
        #1;
        chk("t1_not_rdy", 32'(o_gnt), 32'h0);
        cyc(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("t1_first_gnt", 32'(o_gnt), 32'b0001);
        chk("t1_first_eng", 32'(o_issue_engid), 32'd0);

        // T2: round robin with immediate retire of the previous grant
        cyc(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0);
        chk("t2_gnt_e1", 32'(o_gnt), 32'b0010);
        chk("t2_cred_a", 32'(o_credits_r), 32'd3);
        cyc(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1);
        chk("t2_gnt_e2", 32'(o_gnt), 32'b0100);
        cyc(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2);
        chk("t2_gnt_e3", 32'(o_gnt), 32'b1000);
        chk("t2_eng3", 32'(o_issue_engid), 32'd3);
        cyc(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3);
        chk("t2_wrap_e0", 32'(o_gnt), 32'b0001);
        chk("t2_cred_b", 32'(o_credits_r), 32'd3);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0);
        chk("t2_idle", 32'(o_issue_vld), 32'h0);

        // T3: per-engine hazard, no same-cycle bypass on retire
        cyc(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("t3_cred_back", 32'(o_credits_r), 32'd4);
        chk("t3_gnt_e2", 32'(o_gnt), 32'b0100);
        cyc(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("t3_infl", 32'(o_inflight_r), 32'b0100);
        chk("t3_blk_a", 32'(o_gnt), 32'h0);
        cyc(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("t3_blk_b", 32'(o_gnt), 32'h0);
        cyc(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2);
        chk("t3_no_bypass", 32'(o_gnt), 32'h0);
        cyc(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("t3_regrant", 32'(o_gnt), 32'b0100);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2);

        // T4: credit exhaustion (pointer now at 3)
        cyc(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("t4_cred_full", 32'(o_credits_r), 32'd4);
        chk("t4_g0", 32'(o_gnt), 32'b1000);
        cyc(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("t4_g1", 32'(o_gnt), 32'b0001);
        cyc(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("t4_g2", 32'(o_gnt), 32'b0010);
        cyc(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("t4_g3", 32'(o_gnt), 32'b0100);
        cyc(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("t4_cred0", 32'(o_credits_r), 32'd0);
        chk("t4_infl_all", 32'(o_inflight_r), 32'b1111);
        chk("t4_blocked", 32'(o_gnt), 32'h0);
        cyc(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1);
        chk("t4_ret_no_gnt", 32'(o_gnt), 32'h0);
        cyc(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3);
        chk("t4_cred1", 32'(o_credits_r), 32'd1);
        chk("t4_regnt_e1", 32'(o_gnt), 32'b0010);
        cyc(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("t4_iss_ret_cred", 32'(o_credits_r), 32'd1);
        chk("t4_iss_ret_infl", 32'(o_inflight_r), 32'b0111);
        chk("t4_g_e3", 32'(o_gnt), 32'b1000);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0);
        chk("t4_cred_zero2", 32'(o_credits_r), 32'd0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("t4_recovered", 32'(o_credits_r), 32'd4);
        chk("t4_infl_clr", 32'(o_inflight_r), 32'h0);
        chk("t4_no_err", 32'(o_err_r), 32'h0);

        // T5: allocator gating (pointer now at 0)
        cyc(4'b0011, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0);
        chk("t5_skip_e0", 32'(o_gnt), 32'b0010);
        chk("t5_no_alloc", 32'(o_al_alloc), 32'h0);
        cyc(4'b0001, 4'b0001, 1'b0, 1'b1, 1'b1, 2'd1);
        chk("t5_busy_blk", 32'(o_gnt), 32'h0);
        chk("t5_busy_alloc", 32'(o_al_alloc), 32'h0);
        cyc(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("t5_gnt_e0", 32'(o_gnt), 32'b0001);
        chk("t5_alloc", 32'(o_al_alloc), 32'h1);
        chk("t5_vld", 32'(o_issue_vld), 32'h1);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0);

        // T6: bogus retire sets sticky error without touching state
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3);
        chk("t6_pre_err", 32'(o_err_r), 32'h0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("t6_err", 32'(o_err_r), 32'h1);
        chk("t6_cred", 32'(o_credits_r), 32'd4);
        chk("t6_infl", 32'(o_inflight_r), 32'h0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("t6_sticky", 32'(o_err_r), 32'h1);

        // mid-operation reset clears tracking asynchronously
        cyc(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("rst2_gnt", 32'(o_gnt), 32'b0100);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("rst2_cred_pre", 32'(o_credits_r), 32'd3);
        arst_n = 1'b0;
        #1;
        chk("rst2_err", 32'(o_err_r), 32'h0);
        chk("rst2_cred", 32'(o_credits_r), 32'd4);
        chk("rst2_infl", 32'(o_inflight_r), 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
